// File: rtl/adder_ctrl_pkg.sv
// Shared types and elaboration helpers for the serial adder sequencer.
// Provides the FSM state enum, an index-width helper and the slice-count helper.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Minimum of one bit so a single-slice build still has an index register.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int nslice(input int w, input int s);
    return w / s;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE_W-bit ripple adder built from full-adder cells.
// Ports: a, b, cin in; sum, cout, c_msb (carry into the top bit) out.
module adder_slice
  import adder_ctrl_pkg::*;
#(
  parameter int SLICE_W = 2
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (a[i] & c[i])
                    | (b[i] & c[i]);
  end

  assign cout  = c[SLICE_W];
  assign c_msb = c[SLICE_W-1];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder sharing one SLICE_W-bit slice, LSB slice first.
// Ports: clk, rst, start_i, a_i, b_i, cin_i in; busy_o, done_o, sum_o, cout_o, ovf_o out.
module serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NSLICE = nslice(WIDTH, SLICE_W);
  localparam int IDX_W  = clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NSLICE - 1);

  if (SLICE_W < 1 || WIDTH < SLICE_W ||
      (WIDTH % SLICE_W) != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of SLICE_W");
  end

  state_t state;
  state_t state_d;

  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;
  logic               s_cmsb;
  logic               last;
  logic               accept;

  assign s_a    = a_q[idx*SLICE_W +: SLICE_W];
  assign s_b    = b_q[idx*SLICE_W +: SLICE_W];
  assign last   = (idx == LAST);
  assign accept = start_i && (state != RUN);

  adder_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a     (s_a),
    .b     (s_b),
    .cin   (carry),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Accumulator with the current slice merged in; on the last
  // slice this is the complete sum.
  always_comb begin
    acc_d = acc;
    acc_d[idx*SLICE_W +: SLICE_W] = s_sum;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      carry <= cin_i;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_d;
      carry <= s_cout;
      if (last) begin
        sum_q  <= acc_d;
        cout_q <= s_cout;
        ovf_q  <= s_cmsb ^ s_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule
